// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - parametrised serial bit-pattern detector
// Window/fill tracking with overlap control, saturating match counter and sticky flag.
module serial_pattern_detector #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = 5'b11111,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_valid,
   input  logic             data,
   input  logic             overlap,
   input  logic             clear,
   output logic             detect,
   output logic             detect_sticky,
   output logic [CNT_W-1:0] match_count
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;

   logic [PAT_W-1:0] win;
   logic [FW-1:0]    fill;
   logic [0:0]       state;

   logic [PAT_W-1:0] next_win;
   logic [FW-1:0]    next_fill;
   logic             match;

   // next_* include the bit being presented this cycle
   always_comb begin
      next_win  = {win[PAT_W-2:0], data};
      next_fill = (fill == FULL) ? fill : fill + 1'b1;
      match     = data_valid && (next_win == PATTERN) && (next_fill == FULL);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         win           <= '0;
         fill          <= '0;
         state         <= ST_FILL;
         detect        <= 1'b0;
         detect_sticky <= 1'b0;
         match_count   <= '0;
      end else if (clear) begin
         win           <= '0;
         fill          <= '0;
         state         <= ST_FILL;
         detect        <= 1'b0;
         detect_sticky <= 1'b0;
         match_count   <= '0;
      end else begin
         detect <= match;
         if (data_valid) begin
            if (match && !overlap) begin
               win   <= '0;
               fill  <= '0;
               state <= ST_FILL;
            end else begin
               win   <= next_win;
               fill  <= next_fill;
               state <= (next_fill == FULL) ? ST_ARMED : ST_FILL;
            end
         end
         if (match) begin
            detect_sticky <= 1'b1;
            if (match_count != {CNT_W{1'b1}})
               match_count <= match_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - directed bench for serial_pattern_detector
// Three instances share stimulus: defaults, 2-bit counter, pattern 10110.
module tb_serial_pattern_detector;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic data_valid = 1'b0;
   logic data = 1'b0;
   logic overlap = 1'b1;
   logic clear = 1'b0;

   logic       det0, stk0;
   logic [7:0] cnt0;
   logic       det1, stk1;
   logic [1:0] cnt1;
   logic       det2, stk2;
   logic [7:0] cnt2;

   int tests = 0;
   int fails = 0;
   int idx, p0, p1, p2, first0, last0, first2, last2;

   always #5 clk = ~clk;

   serial_pattern_detector u_dut (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .overlap(overlap),
      .clear(clear), .detect(det0), .detect_sticky(stk0), .match_count(cnt0)
   );

   serial_pattern_detector #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .overlap(overlap),
      .clear(clear), .detect(det1), .detect_sticky(stk1), .match_count(cnt1)
   );

   serial_pattern_detector #(.PATTERN(5'b10110)) u_pat (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .overlap(overlap),
      .clear(clear), .detect(det2), .detect_sticky(stk2), .match_count(cnt2)
   );

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic begin_test();
      idx = 0; p0 = 0; p1 = 0; p2 = 0;
      first0 = -1; last0 = -1; first2 = -1; last2 = -1;
   endtask

   task automatic step(input logic v, input logic d, input logic c);
      @(negedge clk);
      data_valid = v; data = d; clear = c;
      @(posedge clk);
      #1;
      if (det0) begin p0++; if (first0 < 0) first0 = idx; last0 = idx; end
      if (det1) p1++;
      if (det2) begin p2++; if (first2 < 0) first2 = idx; last2 = idx; end
      idx++;
   endtask

   task automatic idle();
      @(negedge clk);
      data_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; data_valid = 1'b0; clear = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic ones(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
   endtask

   logic [14:0] stream1 = 15'b010111110111100;
   logic [7:0]  stream2 = 8'b10110110;

   initial begin
      do_reset();
      check("reset_detect", det0, 0);
      check("reset_sticky", stk0, 0);
      check("reset_count", cnt0, 0);

      // spec stream, one match after the 8th bit
      begin_test();
      overlap = 1'b1;
      for (int i = 14; i >= 0; i--) step(1'b1, stream1[i], 1'b0);
      idle();
      check("s1_pulses", p0, 1);
      check("s1_index", first0, 7);
      check("s1_count", cnt0, 1);
      check("s1_sticky", stk0, 1);

      do_reset();
      begin_test();
      ones(7);
      idle();
      check("ov1_pulses", p0, 3);
      check("ov1_first", first0, 4);
      check("ov1_last", last0, 6);
      check("ov1_count", cnt0, 3);

      do_reset();
      begin_test();
      overlap = 1'b0;
      ones(7);
      idle();
      check("ov0_pulses", p0, 1);
      check("ov0_count", cnt0, 1);

      // valid gap: 1,1,gap x3,1,1,1
      do_reset();
      begin_test();
      overlap = 1'b1;
      ones(2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      ones(3);
      idle();
      check("gap_pulses", p0, 1);
      check("gap_index", first0, 7);
      check("gap_count", cnt0, 1);

      // gap with nonzero count and full window
      begin_test();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      check("gap_hold_count", cnt0, 1);
      check("gap_hold_pulses", p0, 0);
      ones(1);
      idle();
      check("gap_resume_pulses", p0, 1);
      check("gap_resume_count", cnt0, 2);

      // saturation on the 2-bit instance
      do_reset();
      begin_test();
      ones(10);
      idle();
      check("sat_pulses", p1, 6);
      check("sat_count", cnt1, 3);
      check("sat_sticky", stk1, 1);
      check("wide_count", cnt0, 6);

      // reset mid-pattern
      do_reset();
      begin_test();
      ones(4);
      do_reset();
      ones(4);
      check("rst_mid_pulses", p0, 0);
      check("rst_mid_count", cnt0, 0);
      ones(1);
      idle();
      check("rst_mid_fresh", p0, 1);

      // clear mid-pattern
      do_reset();
      begin_test();
      ones(4);
      step(1'b0, 1'b0, 1'b1);
      ones(4);
      check("clr_mid_pulses", p0, 0);
      check("clr_mid_count", cnt0, 0);
      ones(1);
      idle();
      check("clr_mid_fresh", p0, 1);

      // clear beats a match on the same edge
      do_reset();
      overlap = 1'b0;
      ones(5);
      check("pre_clr_count", cnt0, 1);
      begin_test();
      ones(4);
      step(1'b1, 1'b1, 1'b1);
      idle();
      @(posedge clk);
      #1;
      check("clr_win_pulses", p0, 0);
      check("clr_win_detect", det0, 0);
      check("clr_win_count", cnt0, 0);
      check("clr_win_sticky", stk0, 0);

      // pattern 10110, overlapping
      do_reset();
      begin_test();
      overlap = 1'b1;
      for (int i = 7; i >= 0; i--) step(1'b1, stream2[i], 1'b0);
      idle();
      check("pat_pulses", p2, 2);
      check("pat_first", first2, 4);
      check("pat_last", last2, 7);
      check("pat_count", cnt2, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
